// File: rtl/csr_pipe_if.sv
// Bundle of control, payload and status signals between the CSR pipeline
// register and its execute-side driver / writeback consumer / hazard unit.
interface csr_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 1
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              in_we;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_wdata;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] lookup_addr;
  logic              out_valid;
  logic              out_we;
  logic [1:0]        out_op;
  logic [DATA_W-1:0] out_wdata;
  logic [ADDR_W-1:0] out_addr;
  logic              hazard;
  logic [CNT_W-1:0]  inflight_cnt;

  modport master (
    output stall, flush, in_valid, in_we, in_op, in_wdata, in_addr, lookup_addr,
    input  out_valid, out_we, out_op, out_wdata, out_addr, hazard, inflight_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_we, in_op, in_wdata, in_addr, lookup_addr,
    output out_valid, out_we, out_op, out_wdata, out_addr, hazard, inflight_cnt
  );
endinterface

// File: rtl/csr_pipe_stage.sv
// DEPTH-stage execute->writeback CSR pipeline register with stall/flush,
// an in-flight CSR-write counter and an address-match hazard probe.
module csr_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst,
  csr_pipe_if.slave   bus
);

  typedef struct packed {
    logic              v;
    logic              we;
    logic [1:0]        op;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
  } stage_t;

  // Handshake: in_valid marks stage-0 input as a CSR instruction; while stall
  // is high nothing moves and upstream must hold its input; out_* is valid for
  // exactly the cycles out_valid is high and is dropped on the next advance.
  stage_t           r_stage [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  stage_t           w_in;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] w_dec;
  logic             w_hazard;

  // Unqualified inputs collapse to an all-zero bubble so stored we == v & in_we.
  always_comb begin
    w_in = '0;
    if (bus.in_valid) begin
      w_in.v     = 1'b1;
      w_in.we    = bus.in_we;
      w_in.op    = bus.in_op;
      w_in.wdata = bus.in_wdata;
      w_in.addr  = bus.in_addr;
    end
  end

  assign w_inc = CNT_W'(w_in.we);
  assign w_dec = CNT_W'(r_stage[DEPTH-1].we);

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
      r_cnt <= '0;
    end else if (!bus.stall) begin
      r_stage[0] <= w_in;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
      r_cnt <= r_cnt + w_inc - w_dec;
    end
  end

  // Hazard looks only at registered stages, never at the incoming instruction.
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_stage[k].v && r_stage[k].we && (r_stage[k].addr == bus.lookup_addr)) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign bus.out_valid    = r_stage[DEPTH-1].v;
  assign bus.out_we       = r_stage[DEPTH-1].we;
  assign bus.out_op       = r_stage[DEPTH-1].op;
  assign bus.out_wdata    = r_stage[DEPTH-1].wdata;
  assign bus.out_addr     = r_stage[DEPTH-1].addr;
  assign bus.hazard       = w_hazard;
  assign bus.inflight_cnt = r_cnt;

endmodule

// File: tb/tb_csr_pipe_stage.sv
// Directed vector table on a DEPTH=3 instance plus enter/exit and randomised
// popcount regression on a DEPTH=2 instance.
module tb_csr_pipe_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  csr_pipe_if #(.DATA_W(32), .ADDR_W(12), .CNT_W(2)) bus3 ();
  csr_pipe_if #(.DATA_W(32), .ADDR_W(12), .CNT_W(2)) bus2 ();

  csr_pipe_stage #(.DATA_W(32), .ADDR_W(12), .DEPTH(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );
  csr_pipe_stage #(.DATA_W(32), .ADDR_W(12), .DEPTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_n, stall, flush, iv, iwe;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [11:0] ad, lk;
    logic        ev, ewe;
    logic [1:0]  eop;
    logic [31:0] ewd;
    logic [11:0] ead;
    logic        ehz;
    logic [1:0]  ecnt;
  } vec_t;

  typedef struct {
    logic        v, we;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [11:0] ad;
  } mstage_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  mstage_t     m[2];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive3(input vec_t t);
    rst              = t.rst_n;
    bus3.stall       = t.stall;
    bus3.flush       = t.flush;
    bus3.in_valid    = t.iv;
    bus3.in_we       = t.iwe;
    bus3.in_op       = t.op;
    bus3.in_wdata    = t.wd;
    bus3.in_addr     = t.ad;
    bus3.lookup_addr = t.lk;
  endtask

  task automatic drive2(input logic st, input logic fl, input logic iv, input logic we,
                        input logic [1:0] op, input logic [31:0] wd,
                        input logic [11:0] ad, input logic [11:0] lk);
    bus2.stall       = st;
    bus2.flush       = fl;
    bus2.in_valid    = iv;
    bus2.in_we       = we;
    bus2.in_op       = op;
    bus2.in_wdata    = wd;
    bus2.in_addr     = ad;
    bus2.lookup_addr = lk;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive3('{0,0,0,0,0,2'b00,32'h0,12'h0,12'h0, 0,0,2'b00,32'h0,12'h0, 0,2'd0});
    drive2(0, 0, 0, 0, 2'b00, 32'h0, 12'h0, 12'h0);

    // fields: rst,stall,flush,iv,iwe,op,wd,ad,lk | ev,ewe,eop,ewd,ead,ehz,ecnt
    vecs.push_back('{0,0,0,1,1,2'd1,32'h55,12'h300,12'h300, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    vecs.push_back('{0,0,0,1,1,2'd2,32'h66,12'h301,12'h301, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    vecs.push_back('{1,0,0,1,1,2'd1,32'hA1,12'h300,12'h300, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    vecs.push_back('{1,0,0,1,1,2'd2,32'hB2,12'h305,12'h300, 0,0,2'd0,32'h0,12'h0, 1,2'd2});
    vecs.push_back('{1,0,0,1,1,2'd3,32'hC3,12'h341,12'h341, 1,1,2'd1,32'hA1,12'h300, 1,2'd3});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h300, 1,1,2'd2,32'hB2,12'h305, 0,2'd2});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h305, 1,1,2'd3,32'hC3,12'h341, 0,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h341, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    // stall with A1 in stage 1
    vecs.push_back('{1,0,0,1,1,2'd1,32'hA1,12'h300,12'h300, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h300, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1,1,0,1,1,2'd1,32'hD4,12'h300,12'h300, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h300, 1,1,2'd1,32'hA1,12'h300, 1,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h300, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    // flush together with stall
    vecs.push_back('{1,0,0,1,1,2'd1,32'hE1,12'h310,12'h310, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    vecs.push_back('{1,0,0,1,1,2'd1,32'hE2,12'h311,12'h310, 0,0,2'd0,32'h0,12'h0, 1,2'd2});
    vecs.push_back('{1,0,0,1,1,2'd1,32'hE3,12'h312,12'h310, 1,1,2'd1,32'hE1,12'h310, 1,2'd3});
    vecs.push_back('{1,1,1,1,1,2'd1,32'hF0,12'h310,12'h310, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h310, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    // hazard/count: we=1 then we=0 at 0x305
    vecs.push_back('{1,0,0,1,1,2'd1,32'h11,12'h305,12'h305, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    vecs.push_back('{1,0,0,1,0,2'd2,32'h22,12'h305,12'h305, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h305, 1,1,2'd1,32'h11,12'h305, 1,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h305, 1,0,2'd2,32'h22,12'h305, 0,2'd0});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h305, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    // probe a non-matching address
    vecs.push_back('{1,0,0,1,1,2'd1,32'h33,12'h305,12'h306, 0,0,2'd0,32'h0,12'h0, 0,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h306, 0,0,2'd0,32'h0,12'h0, 0,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h306, 1,1,2'd1,32'h33,12'h305, 0,2'd1});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h306, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    // reset mid-operation, then first edge after release advances normally
    vecs.push_back('{1,0,0,1,1,2'd1,32'h44,12'h300,12'h300, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    vecs.push_back('{0,0,0,1,1,2'd1,32'h45,12'h300,12'h300, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    vecs.push_back('{1,0,0,1,1,2'd2,32'h55,12'h301,12'h301, 0,0,2'd0,32'h0,12'h0, 1,2'd1});
    // flush alone, then unqualified input must leave an all-zero bubble
    vecs.push_back('{1,0,1,1,1,2'd1,32'h66,12'h301,12'h301, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    vecs.push_back('{1,0,0,0,1,2'd3,32'h77,12'h301,12'h301, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h301, 0,0,2'd0,32'h0,12'h0, 0,2'd0});
    vecs.push_back('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h301, 0,0,2'd0,32'h0,12'h0, 0,2'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive3(vecs[i]);
      step();
      check($sformatf("v%0d out_valid", i), 64'(bus3.out_valid), 64'(vecs[i].ev));
      check($sformatf("v%0d out_we", i),    64'(bus3.out_we),    64'(vecs[i].ewe));
      check($sformatf("v%0d out_op", i),    64'(bus3.out_op),    64'(vecs[i].eop));
      check($sformatf("v%0d out_wdata", i), 64'(bus3.out_wdata), 64'(vecs[i].ewd));
      check($sformatf("v%0d out_addr", i),  64'(bus3.out_addr),  64'(vecs[i].ead));
      check($sformatf("v%0d hazard", i),    64'(bus3.hazard),    64'(vecs[i].ehz));
      check($sformatf("v%0d inflight", i),  64'(bus3.inflight_cnt), 64'(vecs[i].ecnt));
    end
    drive3('{1,0,0,0,0,2'd0,32'h0,12'h0,12'h0, 0,0,2'd0,32'h0,12'h0, 0,2'd0});

    // DEPTH=2: keep full of we=1 items while new ones enter
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive2(0, 0, 1, 1, 2'd1, 32'h61 + 32'(i), 12'h320 + 12'(i), 12'h320);
        exp_q.push_back(32'h61 + 32'(i));
      end else begin
        drive2(0, 0, 0, 0, 2'd0, 32'h0, 12'h0, 12'h320);
      end
      step();
      if (bus2.out_valid) begin
        if (exp_q.size() == 0) check($sformatf("d2 seq%0d unexpected out", i), 64'(1), 64'(0));
        else check($sformatf("d2 seq%0d out_wdata", i), 64'(bus2.out_wdata), 64'(exp_q.pop_front()));
      end
      case (i)
        0: check("d2 cnt after 1", 64'(bus2.inflight_cnt), 64'(1));
        1, 2, 3: check($sformatf("d2 cnt full %0d", i), 64'(bus2.inflight_cnt), 64'(2));
        4: check("d2 cnt drain1", 64'(bus2.inflight_cnt), 64'(1));
        default: check("d2 cnt drain0", 64'(bus2.inflight_cnt), 64'(0));
      endcase
    end
    check("d2 scoreboard empty", 64'(exp_q.size()), 64'(0));

    // DEPTH=2 random stall/flush/reset regression against a shift model
    m[0] = '{0, 0, 2'd0, 32'h0, 12'h0};
    m[1] = '{0, 0, 2'd0, 32'h0, 12'h0};
    for (int c = 0; c < 300; c++) begin
      logic        st, fl, iv, we, hz;
      logic [1:0]  op;
      logic [31:0] wd;
      logic [11:0] ad, lk;
      int          pc;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 11) == 0);
      iv = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) != 0);
      op = 2'($urandom_range(0, 3));
      wd = $urandom();
      ad = 12'h300 + 12'($urandom_range(0, 3));
      lk = 12'h300 + 12'($urandom_range(0, 3));
      rst = ($urandom_range(0, 39) != 0);
      drive2(st, fl, iv, we, op, wd, ad, lk);
      if (!rst || fl) begin
        m[0] = '{0, 0, 2'd0, 32'h0, 12'h0};
        m[1] = '{0, 0, 2'd0, 32'h0, 12'h0};
      end else if (!st) begin
        m[1] = m[0];
        if (iv) m[0] = '{1, we, op, wd, ad};
        else    m[0] = '{0, 0, 2'd0, 32'h0, 12'h0};
      end
      step();
      hz = 1'b0;
      pc = 0;
      for (int k = 0; k < 2; k++) begin
        if (m[k].v && m[k].we && m[k].ad == lk) hz = 1'b1;
        if (m[k].we) pc++;
      end
      check($sformatf("rnd%0d inflight", c), 64'(bus2.inflight_cnt), 64'(pc));
      check($sformatf("rnd%0d hazard", c),   64'(bus2.hazard),       64'(hz));
      check($sformatf("rnd%0d out", c),
            {14'(0), bus2.out_valid, bus2.out_we, bus2.out_op, bus2.out_wdata, bus2.out_addr},
            {14'(0), m[1].v, m[1].we, m[1].op, m[1].wd, m[1].ad});
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_pipe_stage.md
# csr_pipe_stage

Parametrised, multi-stage pipeline register for CSR instructions between execute and writeback. Each stage carries CSR write data, CSR address, operation code and write-enable with a valid bit, and supports stall (hold) and flush (bubble insertion). It also reports in-flight CSR writes (count plus address-match hazard) so the hazard unit can stall dependent CSR reads. With DEPTH=1 it is the single execute→writeback CSR register, with valid, flush and hazard tracking added.

## Interface
Parameters:
- DATA_W, 32, width of CSR write data
- ADDR_W, 12, width of CSR address
- DEPTH, 1, number of register stages (≥1); input-to-output latency in cycles
- CNT_W, $clog2(DEPTH+1), width of in-flight counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  hold all stages
- flush  in  1  invalidate all stages
- in_valid  in  1  stage-0 input carries a CSR instruction
- in_we  in  1  instruction writes the CSR
- in_op  in  2  CSR op (01 RW, 10 RS, 11 RC, 00 none)
- in_wdata  in  DATA_W  forwarded rs1 or zimm value
- in_addr  in  ADDR_W  CSR address from immediate field
- lookup_addr  in  ADDR_W  address probed by the hazard unit
- out_valid  out  1  last stage valid
- out_we  out  1  last stage write-enable (already qualified by valid)
- out_op  out  2  last stage op
- out_wdata  out  DATA_W  last stage data
- out_addr  out  ADDR_W  last stage address
- hazard  out  1  some valid stage has we=1 and addr==lookup_addr
- inflight_cnt  out  CNT_W  number of stages holding valid && we

## Operation
- Stage k (0..DEPTH-1) holds {v, we, op, wdata, addr}; stage 0 is youngest; out_* = stage DEPTH-1.
- Priority each edge: reset > flush > stall > advance.
- Reset (rst=0): every stage field 0, inflight_cnt=0. All outputs 0.
- Flush: every stage field 0 (payload cleared, not just v); inflight_cnt=0. Overrides stall and discards the current input.
- Stall (flush=0): all stages and inflight_cnt hold; input is ignored (upstream must hold it).
- Advance: stage k ← stage k-1 for k≥1; stage 0 ← input.
- Input qualification: if in_valid=1, stage 0 captures v=1, we=in_we, op, wdata, addr as given. If in_valid=0, stage 0 captures all-zero (v=0, we=0, op=00, payload 0). A stored we is therefore always v&in_we.
- The exiting stage's contents are dropped on advance; the consumer must sample out_* in the cycle they are presented.
- inflight_cnt is a registered counter, not recomputed: on advance, next = cnt + (in_valid&in_we) − stage[DEPTH-1].we. Both terms may occur together, giving net 0. It must always equal the popcount of stage we bits; it never exceeds DEPTH and never underflows.
- hazard is combinational over registered stage state and lookup_addr only (OR of v&we&(addr==lookup_addr) across stages). It does not include the current input. It is independent of stall and flush in the same cycle and reflects state before the edge.

## Timing
- Latency: an input accepted at edge N appears on out_* after edge N+DEPTH-1, i.e. it is visible during cycle N+DEPTH-1..N+DEPTH. Each stall cycle adds one cycle.
- A stall asserted for S cycles delays everything by exactly S cycles; no data is lost or duplicated.
- Flush takes effect at the edge where it is sampled. From the next cycle, out_valid=0, hazard=0 and inflight_cnt=0.
- Reset released mid-operation: the first edge with rst=1 behaves as a normal advance from an all-zero state.
- DEPTH=1: inflight_cnt is 1 bit; the pipeline is one register with the same rules.

## Test plan
- Reset: drive rst=0 for 2 cycles with in_valid=1 and random payload. Expect all out_*=0, hazard=0 and inflight_cnt=0; the first item enters only after rst=1.
- Latency/ordering, DEPTH=3: inject wdata 0xA1, 0xB2, 0xC3 at addr 0x300, 0x305, 0x341 on consecutive cycles. Expect the same triplets on out_* after 3 edges, in order, with out_valid high for 3 cycles.
- Stall: at DEPTH=3 with 0xA1 in stage 1, hold stall for 4 cycles. Expect out_* frozen, inflight_cnt constant, and 0xA1 emerging 4 cycles later than without the stall.
- Flush vs stall: assert stall=1 and flush=1 together with 3 valid writes in flight. Expect out_valid=0, inflight_cnt=0 and hazard=0 on the next cycle.
- Hazard/count: inject we=1 at addr 0x305 and we=0 at addr 0x305. Probe lookup_addr=0x305: hazard=1 only while the we=1 item is in flight, inflight_cnt=1, and both drop to 0 after it exits. Probe 0x306: hazard=0 throughout.
- Simultaneous enter/exit: keep DEPTH=2 full of we=1 items while injecting another we=1 item. Expect inflight_cnt to stay at 2. Include random stall/flush/valid regressions checking inflight_cnt == popcount every cycle.
